// File: rtl/vram_dma_if.sv
// vram_dma_if: CPU-side control, RAM read bus and VRAM write port of the
// VRAM DMA sequencer, bundled for the top level. The DMA engine takes the
// master view; the surrounding system (decoder, RAM, GPU) takes the slave view.
interface vram_dma_if;
  logic        start_write;
  logic [7:0]  start_page;
  logic        in_vblank;
  logic [7:0]  ram_data;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_address;
  logic        dma_read_enable;
  logic [11:0] vram_address;
  logic [7:0]  vram_data;
  logic        vram_write_enable;
  logic        done_pulse;

  modport master (
    input  start_write, start_page, in_vblank, ram_data,
    output cpu_rdy, dma_active, dma_address, dma_read_enable,
           vram_address, vram_data, vram_write_enable, done_pulse
  );

  modport slave (
    output start_write, start_page, in_vblank, ram_data,
    input  cpu_rdy, dma_active, dma_address, dma_read_enable,
           vram_address, vram_data, vram_write_enable, done_pulse
  );
endinterface

// File: rtl/vram_dma.sv
// vram_dma: copies LENGTH bytes from one CPU RAM page into VRAM starting at
// DEST_BASE, halting the CPU while it owns the bus. Two cycles per byte
// (READ then WRITE). All outputs are decoded from registered state only.
// Optional build macro VRAM_DMA_WAIT_VBLANK_EN: only transfer during vblank,
// pausing (CPU still halted) whenever vblank ends mid-transfer.
module vram_dma #(
  parameter int          LENGTH    = 256,
  parameter logic [11:0] DEST_BASE = 12'h000
) (
  input  logic      cpu_clk,
  input  logic      rst,
  vram_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index of the final byte; LENGTH is limited to 1..256 so it fits 9 bits.
  localparam logic [8:0] LAST_IDX = 9'(LENGTH - 1);

  state_t     state_r, state_s;
  logic [7:0] page_r, page_s;
  logic [8:0] idx_r, idx_s;
  logic [7:0] latch_r, latch_s;

  // State, source page, byte index and data latch registers.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_r <= IDLE;
      page_r  <= 8'h00;
      idx_r   <= 9'd0;
      latch_r <= 8'h00;
    end else begin
      state_r <= state_s;
      page_r  <= page_s;
      idx_r   <= idx_s;
      latch_r <= latch_s;
    end
  end

  // Next-state and datapath update; start strobes outside IDLE are ignored.
  always_comb begin
    state_s = state_r;
    page_s  = page_r;
    idx_s   = idx_r;
    latch_s = latch_r;
    case (state_r)
      IDLE: begin
        if (bus.start_write) begin
          page_s  = bus.start_page;
          idx_s   = 9'd0;
          state_s = ARM;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
`ifdef VRAM_DMA_WAIT_VBLANK_EN
        if (bus.in_vblank) begin
          state_s = READ;
        end else begin
          state_s = ARM;
        end
`else
        state_s = READ;
`endif
      end
      READ: begin
        // RAM data is valid throughout READ; capture it on the way out.
        latch_s = bus.ram_data;
        state_s = WRITE;
      end
      WRITE: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          // Index advances here so a vblank pause resumes on the next byte.
          idx_s = idx_r + 9'd1;
`ifdef VRAM_DMA_WAIT_VBLANK_EN
          if (bus.in_vblank) begin
            state_s = READ;
          end else begin
            state_s = ARM;
          end
`else
          state_s = READ;
`endif
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from registered state; address/data buses are zero when idle.
  always_comb begin
    bus.cpu_rdy           = 1'b0;
    bus.dma_active        = 1'b1;
    bus.dma_address       = 16'h0000;
    bus.dma_read_enable   = 1'b0;
    bus.vram_address      = 12'h000;
    bus.vram_data         = 8'h00;
    bus.vram_write_enable = 1'b0;
    bus.done_pulse        = 1'b0;
    case (state_r)
      IDLE: begin
        bus.cpu_rdy    = 1'b1;
        bus.dma_active = 1'b0;
      end
      ARM: begin
        bus.dma_active = 1'b1;
      end
      READ: begin
        bus.dma_read_enable = 1'b1;
        bus.dma_address     = {page_r, 8'h00} + 16'(idx_r);
      end
      WRITE: begin
        bus.vram_write_enable = 1'b1;
        bus.vram_data         = latch_r;
        // 12-bit add wraps the destination modulo 4096.
        bus.vram_address      = DEST_BASE + 12'(idx_r);
      end
      DONE: begin
        bus.done_pulse = 1'b1;
      end
      default: begin
        bus.cpu_rdy    = 1'b1;
        bus.dma_active = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: randomized checks of vram_dma against a transaction-level
// model: a transfer of page P must produce writes (DEST_BASE+i) mod 4096 <-
// mem[{P,i}] for i = 0..LENGTH-1, with the CPU halted 2*LENGTH+2 cycles.
// Two instances: a full-page copy and a short copy that wraps VRAM.
module tb_vram_dma;

  localparam int          LEN_A  = 256;
  localparam logic [11:0] BASE_A = 12'h000;
  localparam int          LEN_B  = 4;
  localparam logic [11:0] BASE_B = 12'hFFE;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic cpu_clk = 1'b0;
  logic rst;
  always #5 cpu_clk = ~cpu_clk;

  vram_dma_if bus_a();
  vram_dma_if bus_b();

  vram_dma #(.LENGTH(LEN_A), .DEST_BASE(BASE_A)) dut_a (
    .cpu_clk(cpu_clk), .rst(rst), .bus(bus_a.master));
  vram_dma #(.LENGTH(LEN_B), .DEST_BASE(BASE_B)) dut_b (
    .cpu_clk(cpu_clk), .rst(rst), .bus(bus_b.master));

  logic [7:0] mem [0:65535];

  assign bus_a.ram_data = bus_a.dma_read_enable ? mem[bus_a.dma_address] : 8'h5A;
  assign bus_b.ram_data = bus_b.dma_read_enable ? mem[bus_b.dma_address] : 8'h5A;

  int tests_run    = 0;
  int tests_failed = 0;

  wr_t        wr_a[$];
  wr_t        wr_b[$];
  int         rdy_low_a, done_a, reads_a, bad_page_a;
  int         rdy_low_b, done_b;
  logic [7:0] exp_page_a;

  // Observe both DUTs away from the active edge.
  always @(negedge cpu_clk) begin
    if (bus_a.vram_write_enable === 1'b1) wr_a.push_back({bus_a.vram_address, bus_a.vram_data});
    if (bus_a.cpu_rdy === 1'b0) rdy_low_a++;
    if (bus_a.done_pulse === 1'b1) done_a++;
    if (bus_a.dma_read_enable === 1'b1) begin
      reads_a++;
      if (bus_a.dma_address[15:8] !== exp_page_a) bad_page_a++;
    end
    if (bus_b.vram_write_enable === 1'b1) wr_b.push_back({bus_b.vram_address, bus_b.vram_data});
    if (bus_b.cpu_rdy === 1'b0) rdy_low_b++;
    if (bus_b.done_pulse === 1'b1) done_b++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_b.delete();
    rdy_low_a = 0; done_a = 0; reads_a = 0; bad_page_a = 0;
    rdy_low_b = 0; done_b = 0;
  endtask

  task automatic fill_page(input logic [7:0] pg, input bit pattern);
    for (int i = 0; i < 256; i++)
      mem[{pg, 8'(i)}] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic start_a(input logic [7:0] pg);
    @(negedge cpu_clk);
    bus_a.start_write = 1'b1;
    bus_a.start_page  = pg;
    @(negedge cpu_clk);
    bus_a.start_write = 1'b0;
    bus_a.start_page  = 8'($urandom);
  endtask

  task automatic start_b(input logic [7:0] pg);
    @(negedge cpu_clk);
    bus_b.start_write = 1'b1;
    bus_b.start_page  = pg;
    @(negedge cpu_clk);
    bus_b.start_write = 1'b0;
    bus_b.start_page  = 8'($urandom);
  endtask

  // Model: byte i lands at (base+i) mod 4096 carrying mem[{page,i}].
  task automatic check_writes(input string tag, input wr_t q[$], input logic [7:0] pg,
                              input int n, input logic [11:0] base);
    check_eq({tag, "_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      check_eq(tag, {q[i].a, q[i].d}, {12'(int'(base) + i), mem[{pg, 8'(i)}]});
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl_a"}, {bus_a.cpu_rdy, bus_a.dma_active, bus_a.dma_read_enable,
             bus_a.vram_write_enable, bus_a.done_pulse}, 5'b10000);
    check_eq({tag, "_bus_a"}, {bus_a.dma_address, bus_a.vram_address, bus_a.vram_data}, 36'h0);
    check_eq({tag, "_ctl_b"}, {bus_b.cpu_rdy, bus_b.dma_active, bus_b.dma_read_enable,
             bus_b.vram_write_enable, bus_b.done_pulse}, 5'b10000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pg;
    rst = 1'b1;
    bus_a.start_write = 1'b0; bus_a.start_page = 8'h00; bus_a.in_vblank = 1'b1;
    bus_b.start_write = 1'b0; bus_b.start_page = 8'h00; bus_b.in_vblank = 1'b1;
    exp_page_a = 8'h00;
    clear_mon();
    run(3);
    // Start strobe coinciding with reset must lose.
    bus_a.start_write = 1'b1; bus_a.start_page = 8'h33;
    run(1);
    bus_a.start_write = 1'b0;
    run(1);
    check_idle("reset");
    rst = 1'b0;
    run(2);
    check_idle("reset_rel");

    // Full page copy with the known pattern.
    exp_page_a = 8'h02;
    fill_page(8'h02, 1'b1);
    fill_page(8'h07, 1'b0);
    clear_mon();
    start_a(8'h02);
    run(600);
    check_writes("pat_wr", wr_a, 8'h02, LEN_A, BASE_A);
    check_eq("pat_rdy_low", rdy_low_a, 2 * LEN_A + 2);
    check_eq("pat_done", done_a, 1);
    check_eq("pat_reads", reads_a, LEN_A);
    check_eq("pat_bad_page", bad_page_a, 0);

    // Second start 10 cycles into a transfer is ignored.
    fill_page(8'h02, 1'b0);
    fill_page(8'h07, 1'b0);
    clear_mon();
    start_a(8'h02);
    run(8);
    start_a(8'h07);
    run(600);
    check_writes("restart_wr", wr_a, 8'h02, LEN_A, BASE_A);
    check_eq("restart_rdy_low", rdy_low_a, 2 * LEN_A + 2);
    check_eq("restart_done", done_a, 1);
    check_eq("restart_bad_page", bad_page_a, 0);

    // Reset during byte 40, then a clean restart.
    pg = 8'($urandom);
    exp_page_a = pg;
    fill_page(pg, 1'b0);
    clear_mon();
    start_a(pg);
    for (int k = 0; k < 200 && wr_a.size() < 40; k++) begin
      @(negedge cpu_clk);
      #1;
    end
    check_eq("abort_reached", wr_a.size(), 40);
    rst = 1'b1;
    @(negedge cpu_clk);
    #1;
    check_eq("abort_rdy", bus_a.cpu_rdy, 1'b1);
    check_eq("abort_active", bus_a.dma_active, 1'b0);
    rst = 1'b0;
    run(30);
    check_writes("abort_wr", wr_a, pg, 40, BASE_A);
    check_eq("abort_done", done_a, 0);
    pg = 8'($urandom);
    exp_page_a = pg;
    fill_page(pg, 1'b0);
    clear_mon();
    start_a(pg);
    run(600);
    check_writes("after_abort_wr", wr_a, pg, LEN_A, BASE_A);
    check_eq("after_abort_rdy_low", rdy_low_a, 2 * LEN_A + 2);
    check_eq("after_abort_done", done_a, 1);
    check_eq("after_abort_bad_page", bad_page_a, 0);

    // Short copy across the VRAM wrap point.
    for (int t = 0; t < 3; t++) begin
      pg = 8'($urandom);
      fill_page(pg, 1'b0);
      clear_mon();
      start_b(pg);
      run(30);
      check_writes("wrap_wr", wr_b, pg, LEN_B, BASE_B);
      if (wr_b.size() == LEN_B) begin
        check_eq("wrap_addr2", wr_b[2].a, 12'h000);
        check_eq("wrap_addr3", wr_b[3].a, 12'h001);
      end else begin
        check_eq("wrap_size", wr_b.size(), LEN_B);
      end
      check_eq("wrap_rdy_low", rdy_low_b, 2 * LEN_B + 2);
      check_eq("wrap_done", done_b, 1);
    end

`ifdef VRAM_DMA_WAIT_VBLANK_EN
    // Hold in ARM until vblank, then pause after byte 99 when vblank ends.
    pg = 8'($urandom);
    exp_page_a = pg;
    fill_page(pg, 1'b0);
    bus_a.in_vblank = 1'b0;
    clear_mon();
    start_a(pg);
    run(30);
    check_eq("vb_wait_reads", reads_a, 0);
    check_eq("vb_wait_rdy", bus_a.cpu_rdy, 1'b0);
    bus_a.in_vblank = 1'b1;
    for (int k = 0; k < 400 && wr_a.size() < 100; k++) begin
      @(negedge cpu_clk);
      #1;
    end
    bus_a.in_vblank = 1'b0;
    check_eq("vb_pause_at", wr_a.size(), 100);
    run(20);
    check_eq("vb_paused_wr", wr_a.size(), 100);
    check_eq("vb_paused_rdy", bus_a.cpu_rdy, 1'b0);
    bus_a.in_vblank = 1'b1;
    run(600);
    check_writes("vb_wr", wr_a, pg, LEN_A, BASE_A);
    if (wr_a.size() > 100) begin
      check_eq("vb_resume_addr", wr_a[100].a, 12'(int'(BASE_A) + 100));
    end else begin
      check_eq("vb_resume_size", wr_a.size(), LEN_A);
    end
    check_eq("vb_done", done_a, 1);
    check_eq("vb_bad_page", bad_page_a, 0);
`else
    // Vblank status is ignored: random toggling changes nothing.
    pg = 8'($urandom);
    exp_page_a = pg;
    fill_page(pg, 1'b0);
    clear_mon();
    start_a(pg);
    for (int k = 0; k < 600; k++) begin
      @(negedge cpu_clk);
      bus_a.in_vblank = 1'($urandom);
    end
    bus_a.in_vblank = 1'b1;
    check_writes("novb_wr", wr_a, pg, LEN_A, BASE_A);
    check_eq("novb_rdy_low", rdy_low_a, 2 * LEN_A + 2);
    check_eq("novb_done", done_a, 1);
`endif

    run(2);
    check_idle("final");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
